frame_rx: RTL

Receive-side command framer between `serial_r` and the `ctrl` state machine. Synchronises the receiver's `done` strobe into the `clk` domain and buffers received bytes in a small FIFO. Parses the UDAR host protocol (init 0x00, servo 0x03 + X + Y, trigger 0x0C) and delivers one decoded command at a time over a valid/ready handshake. This removes `ctrl`'s direct dependence on `rx_done` as a clock and adds inter-byte timeout and overflow detection.

---
 rtl/frame_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/frame_rx.sv
// Receive-side command framer: synchronises the serial receiver's done strobe, buffers bytes
// in a small FIFO and decodes host frames into one command at a time over valid/ready.
module frame_rx #(
  parameter int FIFO_AW   = 2,
  parameter int TO_CYCLES = 500000,
  parameter int TO_LEN    = 19
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_type,
  output logic [7:0] cmd_x,
  output logic [7:0] cmd_y,
  output logic       ovf,
  output logic [7:0] err_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {P_IDLE, P_X, P_Y, P_OUT} state_t;

  state_t             r_state, w_state_next;
  logic               r_s1, r_s2, r_s3;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [TO_LEN-1:0]  r_to_cnt;
  logic [7:0]         r_x_lat;
  logic [1:0]         r_type;
  logic [7:0]         r_x, r_y;
  logic               r_ovf;
  logic [7:0]         r_err_cnt;

  logic       w_cap, w_push, w_drop, w_pop, w_empty, w_full, w_hs, w_to_hit;
  logic       w_load, w_lat_x;
  logic [1:0] w_ld_type;
  logic [7:0] w_ld_x, w_ld_y, w_rd_data;

  // Reset to ones so a done level held through reset is not seen as a fresh byte
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) {r_s3, r_s2, r_s1} <= 3'b111;
    else       {r_s3, r_s2, r_s1} <= {r_s2, r_s1, rx_done};
  end

  assign w_cap     = r_s2 & ~r_s3;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_push    = w_cap & (~w_full | w_pop);
  assign w_drop    = w_cap & ~w_push;
  assign w_rd_data = r_mem[r_rd_ptr];
  assign w_hs      = cmd_valid & cmd_ready;
  // Fires on the edge where the idle count would reach TO_CYCLES-1
  assign w_to_hit  = w_empty && (r_to_cnt == TO_LEN'(TO_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) r_state <= P_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      P_IDLE: if (!w_empty) w_state_next = (w_rd_data == 8'h03) ? P_X : P_OUT;
      P_X:    if (!w_empty) w_state_next = P_Y;
              else if (w_to_hit) w_state_next = P_OUT;
      P_Y:    if (!w_empty || w_to_hit) w_state_next = P_OUT;
      P_OUT:  if (w_hs) w_state_next = P_IDLE;
      default: w_state_next = P_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_lat_x   = 1'b0;
    w_ld_type = 2'd0;
    w_ld_x    = 8'h00;
    w_ld_y    = 8'h00;
    case (r_state)
      P_IDLE: if (!w_empty) begin
        w_pop = 1'b1;
        case (w_rd_data)
          8'h00: w_load = 1'b1;
          8'h03: w_load = 1'b0;
          8'h0C: begin w_load = 1'b1; w_ld_type = 2'd2; end
          default: begin
            w_load    = 1'b1;
            w_ld_type = 2'd3;
            w_ld_x    = 8'd1;
            w_ld_y    = w_rd_data;
          end
        endcase
      end
      P_X: if (!w_empty) begin
        w_pop   = 1'b1;
        w_lat_x = 1'b1;
      end else if (w_to_hit) begin
        w_load = 1'b1; w_ld_type = 2'd3; w_ld_x = 8'd2;
      end
      P_Y: if (!w_empty) begin
        w_pop = 1'b1; w_load = 1'b1; w_ld_type = 2'd1;
        w_ld_x = r_x_lat; w_ld_y = w_rd_data;
      end else if (w_to_hit) begin
        w_load = 1'b1; w_ld_type = 2'd3; w_ld_x = 8'd2;
      end
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt  <= '0;
      r_x_lat   <= 8'h00;
      r_type    <= 2'd0;
      r_x       <= 8'h00;
      r_y       <= 8'h00;
      r_ovf     <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      if (w_pop)
        r_to_cnt <= '0;
      else if ((r_state == P_X || r_state == P_Y) && w_empty)
        r_to_cnt <= r_to_cnt + TO_LEN'(1);
      if (w_lat_x) r_x_lat <= w_rd_data;
      if (w_load) begin
        r_type <= w_ld_type;
        r_x    <= w_ld_x;
        r_y    <= w_ld_y;
      end
      if (w_load && w_ld_type == 2'd3 && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
      if (w_drop)                         r_ovf <= 1'b1;
      else if (w_hs && r_type == 2'd0)    r_ovf <= 1'b0;
    end
  end

  assign cmd_valid = (r_state == P_OUT);
  assign cmd_type  = r_type;
  assign cmd_x     = r_x;
  assign cmd_y     = r_y;
  assign ovf       = r_ovf;
  assign err_cnt   = r_err_cnt;

endmodule
